jpeg_pixel_collector: RTL and testbench
=======================================

// Module: jpeg_pixel_collector
// PURPOSE
//  Sink for the JPEG core pixel output stream (outport_* valid/accept).
//  - Buffers pixels in a small FIFO.
//  - Packs each pixel into one 88-bit ring word for the trace-replay/FSB side (valid/yumi).
//  - Tracks frame completion (pixel count vs width*height) and flags protocol errors
//    (coordinates outside the frame, frame size changing mid-frame).
// PARAMETERS
//  FIFO_DEPTH_P  4   pixel FIFO entries; power of two, >=2
//  CNT_WIDTH_P   32  pixel counter width; must hold width*height
// PORTS
//  clk_i              in   1   clock, all logic on rising edge
//  rst_ni             in   1   synchronous reset, active-low
//  inport_valid_i     in   1   pixel valid from JPEG core
//  inport_width_i     in   16  image width (pixels)
//  inport_height_i    in   16  image height (pixels)
//  inport_pixel_x_i   in   16  pixel column
//  inport_pixel_y_i   in   16  pixel row
//  inport_pixel_r_i   in   8   red
//  inport_pixel_g_i   in   8   green
//  inport_pixel_b_i   in   8   blue
//  inport_accept_o    out  1   pixel accepted this cycle when valid&accept
//  v_o                out  1   packed word valid
//  data_o             out  88  {width,height,x,y,r,g,b}: [87:72],[71:56],[55:40],[39:24],[23:16],[15:8],[7:0]
//  yumi_i             in   1   consumer pops word; legal only while v_o=1
//  frame_done_o       out  1   one-cycle pulse: last pixel of frame accepted
//  frame_cnt_o        out  16  completed frames, wraps at 0xFFFF->0
//  error_o            out  1   sticky protocol error, cleared at next frame start
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge): FIFO emptied; state IDLE; counters=0.
//   - Outputs: inport_accept_o=0, v_o=0, data_o=0, frame_done_o=0, frame_cnt_o=0, error_o=0.
//   - inport_accept_o rises the first cycle after reset deasserts.
//   - Reset mid-frame discards buffered pixels and all frame state.
//  Input handshake: push = inport_valid_i & inport_accept_o.
//   - inport_accept_o = !full, registered occupancy.
//   - A pop in the same cycle does NOT free a slot for that cycle's push (no full bypass).
//  Output handshake: v_o = !empty; data_o = head entry, stable while v_o & !yumi_i.
//   - pop = yumi_i. yumi_i while v_o=0 is ignored (no underflow).
//   - Latency: pixel pushed in cycle N appears on v_o/data_o in cycle N+1 at the earliest.
//   - Simultaneous push and pop (not full, not empty): occupancy unchanged.
//   - Pointers wrap modulo FIFO_DEPTH_P.
//  Frame FSM. Every accepted pixel is queued regardless of state or errors.
//   IDLE: on push -> ACTIVE.
//     - Latch W=width, H=height.
//     - expected = W*H, 32-bit product zero-extended/truncated to CNT_WIDTH_P.
//     - count=1; clear error_o.
//     - If W==0 or H==0: error_o=1 and stay IDLE.
//     - If expected==1: frame_done_o pulses next cycle, frame_cnt_o++, stay IDLE.
//   ACTIVE: on push, count++.
//     - error_o=1 if x>=W, y>=H, width!=W or height!=H.
//     - When count+1==expected: frame_done_o=1 next cycle, frame_cnt_o++, -> IDLE.
//   - Order of pixels is not checked, only the count.
//   - Errors never stall the stream.
//  frame_done_o and frame_cnt_o update the cycle after the completing push.
// TESTING
//  - Reset: hold rst_ni=0 5 cycles -> all outputs 0.
//    Release -> inport_accept_o=1 next cycle, v_o=0.
//  - 2x2 frame, yumi_i=1 always, pixels (0,0..1,1) RGB=0x11,0x22,0x33:
//    - data_o of first = 0x0002_0002_0000_0000_112233.
//    - frame_done_o pulses once after 4th push; frame_cnt_o=1; error_o=0.
//  - Backpressure: yumi_i=0, push FIFO_DEPTH_P pixels -> inport_accept_o=0, v_o=1, data_o=first pixel.
//    - Assert yumi_i 1 cycle -> accept returns next cycle; order preserved.
//  - Out-of-range: 4x1 frame, send x=5 -> error_o=1 and held.
//    - frame still completes after 4 pushes.
//    - Next frame's first push clears error_o.
//  - Size change mid-frame (height 2->3 on 2nd pixel) -> error_o=1.
//    - W=0 frame -> error_o=1, no frame_done_o.
//  - Reset after 3 of 4 pixels: next frame of 4 pixels -> exactly one frame_done_o, frame_cnt_o=1.

Source files
------------

// File: rtl/jpeg_pixel_collector.sv
// jpeg_pixel_collector: sink for the JPEG core pixel stream.
// Buffers accepted pixels in a small FIFO, presents each one as an 88-bit
// word {width,height,x,y,r,g,b} on a valid/yumi port, and tracks frame
// completion and protocol errors against the size latched at frame start.
module jpeg_pixel_collector #(
   parameter int unsigned FIFO_DEPTH_P = 4,
   parameter int unsigned CNT_WIDTH_P  = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    inport_valid_i,
   input  logic [15:0]             inport_width_i,
   input  logic [15:0]             inport_height_i,
   input  logic [15:0]             inport_pixel_x_i,
   input  logic [15:0]             inport_pixel_y_i,
   input  logic [7:0]              inport_pixel_r_i,
   input  logic [7:0]              inport_pixel_g_i,
   input  logic [7:0]              inport_pixel_b_i,
   output logic                    inport_accept_o,
   output logic                    v_o,
   output logic [87:0]             data_o,
   input  logic                    yumi_i,
   output logic                    frame_done_o,
   output logic [15:0]             frame_cnt_o,
   output logic                    error_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH_P);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH_P);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // ---------------- pixel FIFO ----------------
   logic [87:0]      mem [FIFO_DEPTH_P];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [OCC_W-1:0] occ;
   logic             ready;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [87:0]      word;

   assign full  = (occ == DEPTH_OCC);
   assign empty = (occ == '0);
   // Accept is held low through reset and comes up one cycle after release;
   // it depends only on registered occupancy, so a same-cycle pop never
   // makes room for a push.
   assign inport_accept_o = ready & ~full;
   assign push  = inport_valid_i & inport_accept_o;
   assign pop   = yumi_i & ~empty;
   assign v_o   = ~empty;
   assign data_o = empty ? '0 : mem[rd_ptr];
   assign word  = {inport_width_i, inport_height_i, inport_pixel_x_i,
                   inport_pixel_y_i, inport_pixel_r_i, inport_pixel_g_i,
                   inport_pixel_b_i};

   // FIFO pointers, occupancy and the post-reset ready flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // FIFO storage write
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= word;
   end

   // ---------------- frame tracking ----------------
   state_t                 state_q, state_n;
   logic [15:0]            w_q, w_n;
   logic [15:0]            h_q, h_n;
   logic [CNT_WIDTH_P-1:0] exp_q, exp_n;
   logic [CNT_WIDTH_P-1:0] cnt_q, cnt_n;
   logic                   err_q, err_n;
   logic                   done_q, done_n;
   logic [15:0]            fcnt_q, fcnt_n;
   logic [31:0]            prod;
   logic [CNT_WIDTH_P-1:0] prod_c;
   logic                   viol;

   assign prod   = {16'b0, inport_width_i} * {16'b0, inport_height_i};
   assign prod_c = CNT_WIDTH_P'(prod);
   assign viol   = (inport_pixel_x_i >= w_q) || (inport_pixel_y_i >= h_q) ||
                   (inport_width_i != w_q)   || (inport_height_i != h_q);

   // Frame state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_n;
   end

   // Next-state and frame bookkeeping, evaluated only on accepted pixels
   always_comb begin
      state_n = state_q;
      w_n     = w_q;
      h_n     = h_q;
      exp_n   = exp_q;
      cnt_n   = cnt_q;
      err_n   = err_q;
      done_n  = 1'b0;
      fcnt_n  = fcnt_q;
      if (push) begin
         case (state_q)
            IDLE: begin
               w_n   = inport_width_i;
               h_n   = inport_height_i;
               exp_n = prod_c;
               cnt_n = CNT_WIDTH_P'(1);
               err_n = 1'b0;
               if ((inport_width_i == 16'd0) || (inport_height_i == 16'd0)) begin
                  err_n = 1'b1;
               end else if (prod_c == CNT_WIDTH_P'(1)) begin
                  done_n = 1'b1;
                  fcnt_n = fcnt_q + 16'd1;
               end else begin
                  state_n = ACTIVE;
               end
            end
            ACTIVE: begin
               cnt_n = cnt_q + CNT_WIDTH_P'(1);
               if (viol) err_n = 1'b1;
               if ((cnt_q + CNT_WIDTH_P'(1)) == exp_q) begin
                  done_n  = 1'b1;
                  fcnt_n  = fcnt_q + 16'd1;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Frame registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         w_q    <= '0;
         h_q    <= '0;
         exp_q  <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         w_q    <= w_n;
         h_q    <= h_n;
         exp_q  <= exp_n;
         cnt_q  <= cnt_n;
         err_q  <= err_n;
         done_q <= done_n;
         fcnt_q <= fcnt_n;
      end
   end

   assign frame_done_o = done_q;
   assign frame_cnt_o  = fcnt_q;
   assign error_o      = err_q;

endmodule

// File: tb/tb_jpeg_pixel_collector.sv
// Testbench for jpeg_pixel_collector: directed scenarios plus a randomized
// stream, all checked against a queue-based reference model.
module tb_jpeg_pixel_collector;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [15:0] width, height, px, py;
   logic [7:0]  r, g, b;
   logic        yumi;
   logic        accept, v;
   logic [87:0] data;
   logic        done;
   logic [15:0] fcnt;
   logic        err;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [87:0] mq[$];
   bit          m_ready = 0;
   bit          m_in_frame = 0;
   logic [15:0] m_w, m_h;
   logic [31:0] m_exp, m_seen;
   bit          m_err = 0;
   bit          m_done = 0;
   logic [15:0] m_fcnt = 0;
   bit          m_push = 0;

   always #5 clk = ~clk;

   jpeg_pixel_collector #(.FIFO_DEPTH_P(DEPTH), .CNT_WIDTH_P(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .inport_valid_i(valid),
      .inport_width_i(width), .inport_height_i(height),
      .inport_pixel_x_i(px), .inport_pixel_y_i(py),
      .inport_pixel_r_i(r), .inport_pixel_g_i(g), .inport_pixel_b_i(b),
      .inport_accept_o(accept), .v_o(v), .data_o(data), .yumi_i(yumi),
      .frame_done_o(done), .frame_cnt_o(fcnt), .error_o(err));

   function automatic bit m_accept();
      return m_ready && (mq.size() < DEPTH);
   endfunction

   function automatic logic [87:0] m_head();
      return (mq.size() > 0) ? mq[0] : 88'd0;
   endfunction

   // Model: a frame is the next W*H accepted pixels, size taken from its first pixel.
   task automatic model_frame();
      if (!m_in_frame) begin
         m_w = width; m_h = height;
         m_exp = 32'(width) * 32'(height);
         m_seen = 1; m_err = 0;
         if (width == 0 || height == 0) m_err = 1;
         else if (m_exp == 1) begin m_done = 1; m_fcnt = m_fcnt + 1; end
         else m_in_frame = 1;
      end else begin
         m_seen = m_seen + 1;
         if (px >= m_w || py >= m_h || width != m_w || height != m_h) m_err = 1;
         if (m_seen == m_exp) begin
            m_done = 1; m_fcnt = m_fcnt + 1; m_in_frame = 0;
         end
      end
   endtask

   // One clock with the currently driven inputs; sample #1 after the edge.
   task automatic cycle();
      bit do_push, do_pop;
      logic [87:0] w;
      do_push = rst_n && valid && m_accept();
      do_pop  = yumi && (mq.size() > 0);
      w = {width, height, px, py, r, g, b};
      @(posedge clk); #1;
      m_push = 0; m_done = 0;
      if (!rst_n) begin
         mq.delete(); m_ready = 0; m_in_frame = 0; m_err = 0; m_fcnt = 0;
      end else begin
         m_ready = 1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(w); m_push = 1;
            model_frame();
         end
      end
   endtask

   task automatic set_pix(input logic [15:0] w_, h_, x_, y_, input logic [7:0] r_, g_, b_);
      width = w_; height = h_; px = x_; py = y_; r = r_; g = g_; b = b_;
   endtask

   task automatic do_reset();
      rst_n = 0; valid = 0; yumi = 0;
      repeat (2) cycle();
      rst_n = 1;
      cycle();
   endtask

   task automatic test_reset();
      rst_n = 0; valid = 1; yumi = 0;
      set_pix(4, 4, 1, 1, 8'hAA, 8'hBB, 8'hCC);
      repeat (5) cycle();
      checks++; if (accept !== 1'b0) begin errors++; $display("FAIL reset_accept got=%0b exp=0", accept); end
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_v got=%0b exp=0", v); end
      checks++; if (data !== 88'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt got=%0d exp=0", fcnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
      valid = 0; rst_n = 1;
      cycle();
      checks++; if (accept !== 1'b1) begin errors++; $display("FAIL release_accept got=%0b exp=1", accept); end
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL release_v got=%0b exp=0", v); end
   endtask

   task automatic test_frame_2x2();
      int pulses = 0;
      do_reset();
      yumi = 1; valid = 1;
      for (int i = 0; i < 4; i++) begin
         set_pix(2, 2, 16'(i % 2), 16'(i / 2), 8'h11, 8'h22, 8'h33);
         cycle();
         if (i == 0) begin
            checks++;
            if (data !== 88'h0002_0002_0000_0000_112233) begin
               errors++; $display("FAIL f2x2_first_word got=%h exp=0002000200000000112233", data);
            end
         end
         checks++; if (data !== m_head()) begin errors++; $display("FAIL f2x2_data got=%h exp=%h", data, m_head()); end
         if (done) pulses++;
      end
      valid = 0;
      repeat (3) begin cycle(); if (done) pulses++; end
      checks++; if (pulses != 1) begin errors++; $display("FAIL f2x2_done_pulses got=%0d exp=1", pulses); end
      checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL f2x2_fcnt got=%0d exp=1", fcnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL f2x2_err got=%0b exp=0", err); end
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL f2x2_drained got=%0b exp=0", v); end
   endtask

   task automatic test_backpressure();
      logic [87:0] sent[$];
      do_reset();
      yumi = 0; valid = 1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         set_pix(16, 16, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom), 8'($urandom));
         sent.push_back({width, height, px, py, r, g, b});
         cycle();
      end
      checks++; if (accept !== 1'b0) begin errors++; $display("FAIL bp_full_accept got=%0b exp=0", accept); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL bp_full_v got=%0b exp=1", v); end
      checks++; if (data !== sent[0]) begin errors++; $display("FAIL bp_head got=%h exp=%h", data, sent[0]); end
      // full with a pop: the offered pixel must still be refused this cycle
      yumi = 1;
      cycle();
      checks++; if (accept !== 1'b1) begin errors++; $display("FAIL bp_accept_back got=%0b exp=1", accept); end
      checks++; if (data !== sent[1]) begin errors++; $display("FAIL bp_order1 got=%h exp=%h", data, sent[1]); end
      valid = 0;
      for (int k = 2; k < DEPTH + 2; k++) begin
         cycle();
         if (k < DEPTH) begin
            checks++; if (data !== sent[k]) begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", k, data, sent[k]); end
         end
      end
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL bp_empty_v got=%0b exp=0", v); end
      // pops on an empty FIFO are ignored
      repeat (2) cycle();
      valid = 1; set_pix(16, 16, 3, 4, 8'h5A, 8'hA5, 8'h3C); yumi = 0;
      cycle();
      valid = 0;
      checks++; if (data !== 88'h0010_0010_0003_0004_5AA53C) begin errors++; $display("FAIL bp_underflow got=%h exp=00100010000300045aa53c", data); end
      checks++; if (accept !== m_accept() || v !== 1'b1) begin errors++; $display("FAIL bp_underflow_occ got=%0b/%0b exp=%0b/1", accept, v, m_accept()); end
   endtask

   task automatic test_out_of_range();
      int xs[4] = '{0, 5, 2, 3};
      int pulses = 0;
      do_reset();
      yumi = 1; valid = 1;
      for (int i = 0; i < 4; i++) begin
         set_pix(4, 1, 16'(xs[i]), 0, 8'(i), 8'h00, 8'hFF);
         cycle();
         if (done) pulses++;
         if (i >= 1) begin
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err%0d got=%0b exp=1", i, err); end
         end
      end
      valid = 0; cycle(); if (done) pulses++;
      checks++; if (pulses != 1) begin errors++; $display("FAIL oor_done_pulses got=%0d exp=1", pulses); end
      checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL oor_fcnt got=%0d exp=1", fcnt); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err_held got=%0b exp=1", err); end
      valid = 1; set_pix(2, 1, 0, 0, 1, 2, 3);
      cycle();
      valid = 0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got=%0b exp=0", err); end
   endtask

   task automatic test_size_change();
      int pulses = 0;
      do_reset();
      yumi = 1; valid = 1;
      set_pix(2, 2, 0, 0, 1, 1, 1); cycle();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL sz_err_first got=%0b exp=0", err); end
      set_pix(2, 3, 1, 0, 2, 2, 2); cycle();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL sz_err got=%0b exp=1", err); end
      set_pix(2, 2, 0, 1, 3, 3, 3); cycle();
      set_pix(2, 2, 1, 1, 4, 4, 4); cycle();
      valid = 0; cycle();
      checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL sz_fcnt got=%0d exp=1", fcnt); end
      valid = 1; set_pix(0, 5, 0, 0, 9, 9, 9); cycle();
      valid = 0;
      if (done) pulses++;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL w0_err got=%0b exp=1", err); end
      repeat (3) begin cycle(); if (done) pulses++; end
      checks++; if (pulses != 0) begin errors++; $display("FAIL w0_done_pulses got=%0d exp=0", pulses); end
      checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL w0_fcnt got=%0d exp=1", fcnt); end
   endtask

   task automatic test_reset_midframe();
      int pulses = 0;
      do_reset();
      yumi = 0; valid = 1;
      for (int i = 0; i < 3; i++) begin
         set_pix(2, 2, 16'(i % 2), 16'(i / 2), 8'(i), 0, 0); cycle();
      end
      valid = 0; rst_n = 0;
      repeat (2) cycle();
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL mid_reset_v got=%0b exp=0", v); end
      rst_n = 1; cycle();
      yumi = 1; valid = 1;
      for (int i = 0; i < 4; i++) begin
         set_pix(2, 2, 16'(i % 2), 16'(i / 2), 8'(i), 0, 0); cycle();
         if (done) pulses++;
      end
      valid = 0;
      repeat (3) begin cycle(); if (done) pulses++; end
      checks++; if (pulses != 1) begin errors++; $display("FAIL mid_done_pulses got=%0d exp=1", pulses); end
      checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL mid_fcnt got=%0d exp=1", fcnt); end
   endtask

   task automatic test_random();
      int gw = 2, gh = 2, gidx = 0, garea = 4;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         valid = ($urandom_range(0, 3) != 0);
         yumi  = ($urandom_range(0, 2) != 0);
         width = 16'(gw); height = 16'(gh);
         px = (gw == 0) ? 16'd0 : 16'(gidx % gw);
         py = (gw == 0) ? 16'd0 : 16'(gidx / gw);
         if ($urandom_range(0, 11) == 0) px = 16'(gw + $urandom_range(0, 3));
         if (gidx > 0 && $urandom_range(0, 19) == 0) height = 16'(gh + 1);
         r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
         cycle();
         checks++; if (accept !== m_accept()) begin errors++; $display("FAIL rnd_accept c=%0d got=%0b exp=%0b", c, accept, m_accept()); end
         checks++; if (v !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_v c=%0d got=%0b exp=%0b", c, v, mq.size() > 0); end
         checks++; if (data !== m_head()) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data, m_head()); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done c=%0d got=%0b exp=%0b", c, done, m_done); end
         checks++; if (fcnt !== m_fcnt) begin errors++; $display("FAIL rnd_fcnt c=%0d got=%0d exp=%0d", c, fcnt, m_fcnt); end
         checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", c, err, m_err); end
         if (m_push) begin
            gidx++;
            if (gidx >= ((garea == 0) ? 1 : garea)) begin
               gidx = 0;
               gw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
               gh = $urandom_range(1, 3);
               garea = gw * gh;
            end
         end
      end
      valid = 0; yumi = 0;
   endtask

   initial begin
      rst_n = 0; valid = 0; yumi = 0;
      set_pix(0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_frame_2x2();
      test_backpressure();
      test_out_of_range();
      test_size_change();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
